crc32_frame_checker: RTL and testbench
======================================

Name: crc32_frame_checker

Overview:
- Streaming CRC-32 checker for the 1G RX MAC path, fed by the byte-lane datapath after preamble/SFD stripping.
- Processes BYTES_W bytes per beat with byte enables and runs a per-frame state machine.
- Checks the received FCS by residue comparison and reports a one-cycle result strobe with computed CRC, byte count and a good/bad verdict.
- Keeps saturating good/bad frame counters for MAC statistics.

Parameters:
- BYTES_W, 1, byte lanes per beat (1, 2, 4 or 8); data width is 8*BYTES_W.
- MIN_FRAME, 64, minimum legal frame length in bytes including FCS.
- MAX_FRAME, 1518, maximum legal frame length in bytes including FCS.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  beat valid; there is no backpressure, so every valid beat is consumed.
- data_i  in  8*BYTES_W  beat data; lane 0 is bits [7:0] and is the earliest byte; each byte is fed LSB first.
- keep_i  in  BYTES_W  byte enables.
- last_i  in  1  final beat of frame, which includes the 4 FCS bytes.
- abort_i  in  1  PHY error on this beat; sampled only with valid_i.
- clr_cnt_i  in  1  synchronous clear of the statistics counters.
- result_valid_o  out  1  one-cycle strobe, one cycle after the last beat.
- crc_o  out  32  standard-form CRC: bit-reversed, complemented register value.
- fcs_ok_o  out  1  residue matched.
- frame_good_o  out  1  overall verdict.
- byte_count_o  out  16  bytes in frame including FCS; saturates at 16'hFFFF.
- good_cnt_o  out  CNT_W  good-frame count.
- bad_cnt_o  out  CNT_W  bad-frame count.

Behaviour:
- CRC arithmetic
  - Polynomial is CRC_POLY from crc_pkg, in MSB-first shift form.
  - For each data bit: fb = crc[31] ^ bit; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
  - Within a beat, enabled lanes are processed in order 0 to BYTES_W-1; lanes whose keep bit is clear are skipped.
  - The full beat update is combinational; the register updates once per valid beat.
- States: IDLE, IN_FRAME.
  - IDLE: a valid beat starts the frame. The CRC is seeded with 32'hFFFFFFFF before applying that beat, and the byte counter and error flags are seeded in the same way.
  - If that beat also has last_i set, the frame completes in the same beat and the state stays IDLE.
  - IN_FRAME: valid beats accumulate. A beat with last_i set returns the state to IDLE.
  - A beat arriving in IDLE immediately after a completing last beat starts a new frame back-to-back. No idle gap is required.
- Keep rules
  - A non-last beat must have keep all ones. Otherwise the keep_err flag is set.
  - A last beat must have contiguous ones from lane 0 and at least one bit set. Otherwise keep_err is set.
  - The offending beat's enabled lanes are still processed.
- Error flags: abort_i sets the abort flag for the frame. The frame continues to be consumed until last_i.
- Result, registered 1 cycle after the last beat
  - fcs_ok_o = (final register == CRC_RESIDUE), where CRC_RESIDUE = 32'hC704DD7B in crc_pkg.
  - frame_good_o = fcs_ok & !abort & !keep_err & (MIN_FRAME <= count <= MAX_FRAME).
  - crc_o = ~bitrev(final register).
  - crc_o, fcs_ok_o, frame_good_o and byte_count_o hold their value until the next strobe.
- Counters
  - On each strobe, good_cnt_o or bad_cnt_o increments by exactly one. Both counters saturate at all ones.
  - clr_cnt_i zeros both counters and takes priority over a same-cycle increment.
- Reset values
  - State IDLE, CRC register all ones.
  - All outputs 0, except crc_o = 32'h00000000.
  - Reset mid-frame discards the partial frame; no strobe is produced for it.
- valid_i low mid-frame is a gap: all state holds.

Test Plan:
- BYTES_W=1, bytes "123456789", last on '9' -> result_valid_o one cycle later with crc_o=32'hCBF43926 and byte_count_o=9; frame_good_o=0 because the frame is a runt.
- BYTES_W=4, 60-byte frame plus a correct appended FCS (64 bytes, last keep=4'b1111) -> fcs_ok_o=1, frame_good_o=1, good_cnt_o=1.
- Same frame with a correct FCS but 61 payload bytes (65 total, last keep=4'b0001) -> byte_count_o=65, good; then one FCS bit flipped -> fcs_ok_o=0, bad_cnt_o=1.
- Two good frames back-to-back, second starting the cycle after last -> two strobes on consecutive frames, with no idle cycle required between them; valid_i gaps inside a frame do not alter crc_o.
- abort_i on a mid beat of a frame with a valid FCS -> fcs_ok_o=1, frame_good_o=0. Non-contiguous keep 4'b0101 on the last beat -> frame_good_o=0.
- Reset asserted mid-frame, then a good frame -> exactly one strobe, frame_good_o=1. clr_cnt_i in the strobe cycle -> counters both 0.

Source files
------------

// File: rtl/crc32_frame_checker.sv
// Streaming CRC-32 frame checker for the RX MAC byte-lane path.
// Verifies the FCS by residue comparison and keeps good/bad frame statistics.
package crc_pkg;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
endpackage

module crc32_frame_checker #(
    parameter int BYTES_W   = 1,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 valid_i,
    input  logic [8*BYTES_W-1:0] data_i,
    input  logic [BYTES_W-1:0]   keep_i,
    input  logic                 last_i,
    input  logic                 abort_i,
    input  logic                 clr_cnt_i,
    output logic                 result_valid_o,
    output logic [31:0]          crc_o,
    output logic                 fcs_ok_o,
    output logic                 frame_good_o,
    output logic [15:0]          byte_count_o,
    output logic [CNT_W-1:0]     good_cnt_o,
    output logic [CNT_W-1:0]     bad_cnt_o
);
    typedef enum logic {S_IDLE, S_IN_FRAME} state_t;

    state_t             r_state, w_state_next;
    logic [31:0]        r_crc, w_crc_base, w_crc_next, w_crc_rev;
    logic [15:0]        r_count, w_count_base, w_count_next, w_lanes;
    logic [16:0]        w_count_sum;
    logic               r_abort, r_keep_err, w_abort_next, w_keep_err_next, w_keep_bad;
    logic [BYTES_W-1:0] w_keep_plus1;
    logic               w_len_ok, w_fcs_ok;
    logic               r_result_valid, r_fcs_ok, r_frame_good;
    logic [31:0]        r_crc_out;
    logic [15:0]        r_byte_count;
    logic [CNT_W-1:0]   r_good_cnt, r_bad_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (valid_i) w_state_next = last_i ? S_IDLE : S_IN_FRAME;
    end

    // A beat seen in IDLE starts a fresh frame, so seed from constants instead of the registers.
    always_comb begin : crc_update
        logic fb;
        fb         = 1'b0;
        w_crc_base = (r_state == S_IDLE) ? 32'hFFFF_FFFF : r_crc;
        w_crc_next = w_crc_base;
        for (int l = 0; l < BYTES_W; l++) begin
            if (keep_i[l]) begin
                for (int b = 0; b < 8; b++) begin
                    fb         = w_crc_next[31] ^ data_i[8*l+b];
                    w_crc_next = {w_crc_next[30:0], 1'b0} ^ (fb ? crc_pkg::CRC_POLY : 32'h0);
                end
            end
        end
    end

    always_comb begin
        w_crc_rev = '0;
        for (int i = 0; i < 32; i++) w_crc_rev[i] = w_crc_next[31-i];
    end

    always_comb begin
        w_lanes = '0;
        for (int l = 0; l < BYTES_W; l++) w_lanes = w_lanes + 16'(keep_i[l]);
        w_count_base = (r_state == S_IDLE) ? 16'h0 : r_count;
        w_count_sum  = {1'b0, w_count_base} + {1'b0, w_lanes};
        w_count_next = w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
    end

    // Contiguous-from-lane-0 keep has no set bit above a clear one: keep & (keep+1) == 0.
    always_comb begin
        w_keep_plus1 = keep_i + BYTES_W'(1);
        if (last_i) w_keep_bad = (keep_i == '0) || ((keep_i & w_keep_plus1) != '0);
        else        w_keep_bad = (keep_i != '1);
        w_abort_next    = ((r_state == S_IDLE) ? 1'b0 : r_abort) | abort_i;
        w_keep_err_next = ((r_state == S_IDLE) ? 1'b0 : r_keep_err) | w_keep_bad;
        w_fcs_ok        = (w_crc_next == crc_pkg::CRC_RESIDUE);
        w_len_ok        = (w_count_next >= 16'(MIN_FRAME)) && (w_count_next <= 16'(MAX_FRAME));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_crc      <= 32'hFFFF_FFFF;
            r_count    <= '0;
            r_abort    <= 1'b0;
            r_keep_err <= 1'b0;
        end else if (valid_i) begin
            r_crc      <= w_crc_next;
            r_count    <= w_count_next;
            r_abort    <= w_abort_next;
            r_keep_err <= w_keep_err_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_result_valid <= 1'b0;
            r_crc_out      <= '0;
            r_fcs_ok       <= 1'b0;
            r_frame_good   <= 1'b0;
            r_byte_count   <= '0;
        end else begin
            r_result_valid <= valid_i & last_i;
            if (valid_i && last_i) begin
                r_crc_out    <= ~w_crc_rev;
                r_fcs_ok     <= w_fcs_ok;
                r_frame_good <= w_fcs_ok & ~w_abort_next & ~w_keep_err_next & w_len_ok;
                r_byte_count <= w_count_next;
            end
        end
    end

    // Statistics follow the strobe by one cycle, so a clear during the strobe wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (clr_cnt_i) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (r_result_valid) begin
            if (r_frame_good) begin
                if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + 1'b1;
            end else begin
                if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + 1'b1;
            end
        end
    end

    assign result_valid_o = r_result_valid;
    assign crc_o          = r_crc_out;
    assign fcs_ok_o       = r_fcs_ok;
    assign frame_good_o   = r_frame_good;
    assign byte_count_o   = r_byte_count;
    assign good_cnt_o     = r_good_cnt;
    assign bad_cnt_o      = r_bad_cnt;
endmodule

// File: tb/tb_crc32_frame_checker.sv
// Directed bench for crc32_frame_checker: one byte-lane and one four-lane instance.
// Expected CRCs come from a reflected-form software CRC-32 independent of the DUT.
module tb_crc32_frame_checker;
    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        valid1 = 0, last1 = 0, abort1 = 0, clr1 = 0;
    logic [7:0]  data1 = 0;
    logic [0:0]  keep1 = 0;
    logic        rv1, ok1, good1;
    logic [31:0] crc1, gc1, bcnt1;
    logic [15:0] bc1;

    logic        valid4 = 0, last4 = 0, abort4 = 0, clr4 = 0;
    logic [31:0] data4 = 0;
    logic [3:0]  keep4 = 0;
    logic        rv4, ok4, good4;
    logic [31:0] crc4, gc4, bcnt4;
    logic [15:0] bc4;

    crc32_frame_checker #(.BYTES_W(1)) dut1 (
        .clk_i(clk_sys), .rst_n_i(rst_n), .valid_i(valid1), .data_i(data1), .keep_i(keep1),
        .last_i(last1), .abort_i(abort1), .clr_cnt_i(clr1), .result_valid_o(rv1), .crc_o(crc1),
        .fcs_ok_o(ok1), .frame_good_o(good1), .byte_count_o(bc1), .good_cnt_o(gc1), .bad_cnt_o(bcnt1));

    crc32_frame_checker #(.BYTES_W(4)) dut4 (
        .clk_i(clk_sys), .rst_n_i(rst_n), .valid_i(valid4), .data_i(data4), .keep_i(keep4),
        .last_i(last4), .abort_i(abort4), .clr_cnt_i(clr4), .result_valid_o(rv4), .crc_o(crc4),
        .fcs_ok_o(ok4), .frame_good_o(good4), .byte_count_o(bc4), .good_cnt_o(gc4), .bad_cnt_o(bcnt4));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobe_n = 0;
    logic [7:0]  frame_buf [0:1599];
    logic [31:0] s_crc  [0:31];
    logic        s_good [0:31];
    int          s_cyc  [0:31];

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (rv4) begin
            s_crc[strobe_n & 31]  = crc4;
            s_good[strobe_n & 31] = good4;
            s_cyc[strobe_n & 31]  = cyc;
            strobe_n++;
        end
    end

    function automatic logic [31:0] ref_crc(input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, frame_buf[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int payload, input int seed);
        logic [31:0] c;
        for (int i = 0; i < payload; i++) frame_buf[i] = 8'((i * 7 + seed) & 8'hFF);
        c = ref_crc(payload);
        for (int k = 0; k < 4; k++) frame_buf[payload + k] = c[8*k +: 8];
    endtask

    task automatic send_frame4(input int len, input int abort_beat, input int gap_beat,
                               input bit use_ovr, input logic [3:0] ovr);
        int beats, rem;
        beats = (len + 3) / 4;
        rem   = len - 4 * (beats - 1);
        for (int b = 0; b < beats; b++) begin
            if (b == gap_beat) begin
                @(negedge clk_sys);
                valid4 = 1'b0;
            end
            @(negedge clk_sys);
            valid4 = 1'b1;
            data4  = '0;
            for (int l = 0; l < 4; l++)
                if (4 * b + l < len) data4[8*l +: 8] = frame_buf[4*b + l];
            if (b == beats - 1) keep4 = use_ovr ? ovr : 4'((1 << rem) - 1);
            else                keep4 = 4'hF;
            last4  = (b == beats - 1);
            abort4 = (b == abort_beat);
        end
    endtask

    task automatic idle4();
        @(negedge clk_sys);
        valid4 = 1'b0; last4 = 1'b0; abort4 = 1'b0; keep4 = '0;
        #1;
    endtask

    task automatic wait_strobe(input int target, input string name);
        for (int i = 0; i < 8 && strobe_n < target; i++) begin
            @(negedge clk_sys);
            #1;
        end
        checks++;
        if (strobe_n < target) begin
            errors++;
            $display("FAIL %s: strobe count %0d, required %0d", name, strobe_n, target);
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rv4 !== 1'b0)    begin errors++; $display("FAIL reset_rv: got %0b want 0", rv4); end
        checks++; if (crc4 !== 32'h0)  begin errors++; $display("FAIL reset_crc: got %h want 0", crc4); end
        checks++; if (ok4 !== 1'b0)    begin errors++; $display("FAIL reset_ok: got %0b want 0", ok4); end
        checks++; if (good4 !== 1'b0)  begin errors++; $display("FAIL reset_good: got %0b want 0", good4); end
        checks++; if (bc4 !== 16'h0)   begin errors++; $display("FAIL reset_bc: got %0d want 0", bc4); end
        checks++; if (gc4 !== 32'h0 || bcnt4 !== 32'h0)
            begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", gc4, bcnt4); end
        checks++; if (crc1 !== 32'h0)  begin errors++; $display("FAIL reset_crc1: got %h want 0", crc1); end
    endtask

    task automatic test_check_string();
        logic [7:0] s [0:8];
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_sys);
            valid1 = 1'b1; keep1 = 1'b1; data1 = s[i]; last1 = (i == 8);
        end
        @(negedge clk_sys);
        valid1 = 1'b0; last1 = 1'b0; keep1 = 1'b0;
        #1;
        checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL check_rv: got %0b want 1", rv1); end
        checks++; if (crc1 !== 32'hCBF4_3926) begin errors++; $display("FAIL check_crc: got %h want cbf43926", crc1); end
        checks++; if (bc1 !== 16'd9) begin errors++; $display("FAIL check_bc: got %0d want 9", bc1); end
        checks++; if (good1 !== 1'b0) begin errors++; $display("FAIL check_runt: got %0b want 0", good1); end
        settle(2);
        checks++; if (bcnt1 !== 32'd1 || gc1 !== 32'd0)
            begin errors++; $display("FAIL check_cnt: got good=%0d bad=%0d want 0/1", gc1, bcnt1); end
    endtask

    task automatic test_good_64();
        int n0;
        n0 = strobe_n;
        build_frame(60, 3);
        send_frame4(64, -1, -1, 0, 4'h0);
        idle4();
        checks++; if (rv4 !== 1'b1) begin errors++; $display("FAIL g64_latency: rv %0b want 1", rv4); end
        wait_strobe(n0 + 1, "g64_strobe");
        checks++; if (ok4 !== 1'b1 || good4 !== 1'b1)
            begin errors++; $display("FAIL g64_ok: got ok=%0b good=%0b want 1/1", ok4, good4); end
        checks++; if (crc4 !== ref_crc(64)) begin errors++; $display("FAIL g64_crc: got %h want %h", crc4, ref_crc(64)); end
        checks++; if (bc4 !== 16'd64) begin errors++; $display("FAIL g64_bc: got %0d want 64", bc4); end
        settle(2);
        checks++; if (gc4 !== 32'd1) begin errors++; $display("FAIL g64_gcnt: got %0d want 1", gc4); end
    endtask

    task automatic test_odd_len();
        int n0;
        n0 = strobe_n;
        build_frame(61, 11);
        send_frame4(65, -1, -1, 0, 4'h0);
        idle4();
        wait_strobe(n0 + 1, "odd_strobe");
        checks++; if (bc4 !== 16'd65) begin errors++; $display("FAIL odd_bc: got %0d want 65", bc4); end
        checks++; if (good4 !== 1'b1) begin errors++; $display("FAIL odd_good: got %0b want 1", good4); end
        frame_buf[10] = frame_buf[10] ^ 8'h01;
        send_frame4(65, -1, -1, 0, 4'h0);
        idle4();
        wait_strobe(n0 + 2, "flip_strobe");
        checks++; if (ok4 !== 1'b0 || good4 !== 1'b0)
            begin errors++; $display("FAIL flip_ok: got ok=%0b good=%0b want 0/0", ok4, good4); end
        checks++; if (crc4 !== ref_crc(65)) begin errors++; $display("FAIL flip_crc: got %h want %h", crc4, ref_crc(65)); end
        settle(2);
        checks++; if (gc4 !== 32'd2 || bcnt4 !== 32'd1)
            begin errors++; $display("FAIL odd_cnt: got good=%0d bad=%0d want 2/1", gc4, bcnt4); end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = strobe_n;
        build_frame(60, 29);
        send_frame4(64, -1, 5, 0, 4'h0);
        send_frame4(64, -1, -1, 0, 4'h0);
        idle4();
        wait_strobe(n0 + 2, "b2b_strobe");
        checks++; if (s_cyc[(n0+1) & 31] - s_cyc[n0 & 31] != 16)
            begin errors++; $display("FAIL b2b_spacing: got %0d want 16", s_cyc[(n0+1) & 31] - s_cyc[n0 & 31]); end
        checks++; if (s_crc[n0 & 31] !== ref_crc(64) || s_crc[(n0+1) & 31] !== ref_crc(64))
            begin errors++; $display("FAIL b2b_crc: got %h/%h want %h", s_crc[n0 & 31], s_crc[(n0+1) & 31], ref_crc(64)); end
        checks++; if (s_good[n0 & 31] !== 1'b1 || s_good[(n0+1) & 31] !== 1'b1)
            begin errors++; $display("FAIL b2b_good: got %0b/%0b want 1/1", s_good[n0 & 31], s_good[(n0+1) & 31]); end
        settle(2);
        checks++; if (gc4 !== 32'd4) begin errors++; $display("FAIL b2b_gcnt: got %0d want 4", gc4); end
    endtask

    task automatic test_errors();
        int n0;
        n0 = strobe_n;
        build_frame(60, 41);
        send_frame4(64, 3, -1, 0, 4'h0);
        idle4();
        wait_strobe(n0 + 1, "abort_strobe");
        checks++; if (ok4 !== 1'b1 || good4 !== 1'b0)
            begin errors++; $display("FAIL abort_verdict: got ok=%0b good=%0b want 1/0", ok4, good4); end
        send_frame4(64, -1, -1, 1, 4'b0101);
        idle4();
        wait_strobe(n0 + 2, "keep_strobe");
        checks++; if (good4 !== 1'b0) begin errors++; $display("FAIL keep_good: got %0b want 0", good4); end
        checks++; if (bc4 !== 16'd62) begin errors++; $display("FAIL keep_bc: got %0d want 62", bc4); end
        settle(2);
        checks++; if (bcnt4 !== 32'd3) begin errors++; $display("FAIL err_bcnt: got %0d want 3", bcnt4); end
    endtask

    task automatic test_reset_mid();
        int n0;
        build_frame(60, 53);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk_sys);
            valid4 = 1'b1; keep4 = 4'hF; last4 = 1'b0; data4 = {frame_buf[4*b+3], frame_buf[4*b+2], frame_buf[4*b+1], frame_buf[4*b]};
        end
        @(negedge clk_sys);
        valid4 = 1'b0; rst_n = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        n0 = strobe_n;
        send_frame4(64, -1, -1, 0, 4'h0);
        idle4();
        wait_strobe(n0 + 1, "rmid_strobe");
        settle(4);
        checks++; if (strobe_n != n0 + 1) begin errors++; $display("FAIL rmid_count: got %0d strobes want 1", strobe_n - n0); end
        checks++; if (good4 !== 1'b1) begin errors++; $display("FAIL rmid_good: got %0b want 1", good4); end
        checks++; if (gc4 !== 32'd1 || bcnt4 !== 32'd0)
            begin errors++; $display("FAIL rmid_cnt: got good=%0d bad=%0d want 1/0", gc4, bcnt4); end
    endtask

    task automatic test_clear();
        build_frame(60, 67);
        send_frame4(64, -1, -1, 0, 4'h0);
        idle4();
        checks++; if (rv4 !== 1'b1) begin errors++; $display("FAIL clr_strobe: rv %0b want 1", rv4); end
        clr4 = 1'b1;
        @(negedge clk_sys);
        clr4 = 1'b0;
        settle(2);
        checks++; if (gc4 !== 32'd0 || bcnt4 !== 32'd0)
            begin errors++; $display("FAIL clr_cnt: got good=%0d bad=%0d want 0/0", gc4, bcnt4); end
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        test_reset();
        rst_n = 1'b1;
        settle(2);
        test_check_string();
        test_good_64();
        test_odd_len();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
